// File: rtl/stopwatch_ctrl_if.sv
// Counter-chain / display side of the stopwatch sequencer.
// Handshake: there is no backpressure on this bundle. cnt_en and cnt_clr are
// one-clk qualifiers that the counter chain must act on in the cycle they are
// high (the "ready" side is always ready); time_bcd is a continuously valid
// level from the counters; disp_bcd/freeze/run_led/state are continuously
// valid levels toward the display and debug logic.
interface stopwatch_ctrl_if;
  logic [23:0] time_bcd;
  logic        cnt_en;
  logic        cnt_clr;
  logic [23:0] disp_bcd;
  logic        freeze;
  logic        run_led;
  logic [1:0]  state;

  // Sequencer side
  modport master (
    input  time_bcd,
    output cnt_en, cnt_clr, disp_bcd, freeze, run_led, state
  );

  // Counter chain / display side
  modport slave (
    output time_bcd,
    input  cnt_en, cnt_clr, disp_bcd, freeze, run_led, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button debounce, run/stop/lap/clear FSM,
// tick gating into the BCD counter chain and lap snapshot for the display.
// Optional feature macro: STOPWATCH_CTRL_LAP_EN enables the lap capture and
// LAP state; without it lap_p only clears the counters in IDLE/STOP.
module stopwatch_ctrl #(
  parameter int DB_CYCLES = 250000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             btn_ss,
  input  logic             btn_lap,
  stopwatch_ctrl_if.master bus
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAP  = 2'd2,
    ST_STOP = 2'd3
  } state_e;

  // Bit 0 = start/stop button, bit 1 = lap/reset button.
  logic [1:0] btn_raw;
  assign btn_raw = {btn_lap, btn_ss};

  // Debounce state
  logic [1:0]          sync1_q, sync1_d;
  logic [1:0]          sync2_q, sync2_d;
  logic [1:0]          vld_q,   vld_d;    // sync2 holds a real sample, not reset fill
  logic [1:0]          arm_q,   arm_d;    // button has been seen released since reset
  logic [1:0]          acc_q,   acc_d;    // accepted (debounced) level
  logic [1:0]          press_q, press_d;  // one-clk press pulses
  logic [1:0][CW-1:0]  cnt_q,   cnt_d;    // consecutive samples differing from acc

  logic ss_p;
  logic lap_p;
  assign ss_p  = press_q[0];
  assign lap_p = press_q[1];

  // FSM state
  state_e state_q, state_d;
  logic   clr_q,   clr_d;

  // Debounce next-state: synchronize, count stability, accept, detect rise.
  // A press pulse is only issued once the button has been observed low after
  // reset, so a button held through reset cannot start the stopwatch.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    vld_d   = {vld_q[0], 1'b1};
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    arm_d   = arm_q;
    press_d = 2'b00;
    for (int i = 0; i < 2; i++) begin
      arm_d[i] = arm_q[i] | (vld_q[1] & ~sync2_q[i]);
      if (sync2_q[i] == acc_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]   = '0;
        acc_d[i]   = sync2_q[i];
        press_d[i] = sync2_q[i] & arm_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Debounce registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      vld_q   <= '0;
      arm_q   <= '0;
      acc_q   <= '0;
      press_q <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      vld_q   <= vld_d;
      arm_q   <= arm_d;
      acc_q   <= acc_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef STOPWATCH_CTRL_LAP_EN
  logic [23:0] lap_q, lap_d;
  logic        lap_cap;
`endif

  // FSM next-state; start/stop wins over lap when both pulse together.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
`ifdef STOPWATCH_CTRL_LAP_EN
    lap_cap = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ss_p) begin
          state_d = ST_RUN;
        end else if (lap_p) begin
          clr_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (ss_p) begin
          state_d = ST_STOP;
        end else if (lap_p) begin
`ifdef STOPWATCH_CTRL_LAP_EN
          state_d = ST_LAP;
          lap_cap = 1'b1;
`endif
        end
      end
      ST_LAP: begin
        if (ss_p) begin
          state_d = ST_STOP;
        end else if (lap_p) begin
          state_d = ST_RUN;
        end
      end
      ST_STOP: begin
        if (ss_p) begin
          state_d = ST_RUN;
        end else if (lap_p) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and registered clear pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  logic running;
  assign running = (state_q == ST_RUN) || (state_q == ST_LAP);

`ifdef STOPWATCH_CTRL_LAP_EN
  // Lap snapshot next value: only the RUN->LAP transition loads it.
  always_comb begin
    lap_d = lap_q;
    if (lap_cap) begin
      lap_d = bus.time_bcd;
    end
  end

  // Lap snapshot register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_q <= '0;
    end else begin
      lap_q <= lap_d;
    end
  end

  assign bus.freeze   = (state_q == ST_LAP);
  assign bus.disp_bcd = bus.freeze ? lap_q : bus.time_bcd;
`else
  assign bus.freeze   = 1'b0;
  assign bus.disp_bcd = bus.time_bcd;
`endif

  // Tick gating is combinational from the registered state so the counter
  // chain sees the tick in the same cycle it arrives.
  assign bus.cnt_en  = tick & running;
  assign bus.cnt_clr = clr_q;
  assign bus.run_led = running;
  assign bus.state   = state_q;

  // Clear is only issued from IDLE/STOP, so it can never overlap an enable.
  a_clr_not_en: assert property (@(posedge clk) disable iff (rst)
    !(bus.cnt_en && bus.cnt_clr));

endmodule
